avion_cpu_v2: RTL and testbench
===============================

Name: avion_cpu_v2

Overview:
Parametrised successor to the Avion accumulator CPU. It keeps the same single-port synchronous RAM interface (one-cycle read latency) and the same opcode map. New in this generation: width-generic datapath, logic/branch-on-carry opcodes, carry/zero flags, an iterative multi-cycle divider, divide-by-zero and illegal-opcode reporting, and an explicit halted status. It instantiates under the same testbench/blram harness as its predecessor.

Parameters:
ADDRESS_WIDTH, 6, RAM address width; also PC and operand field width.
DATA_WIDTH, 10, ACC/RAM word width; must equal OPCODE_WIDTH + ADDRESS_WIDTH (elaboration error otherwise).
OPCODE_WIDTH, 4, instruction opcode field width (IR[DATA_WIDTH-1 -: OPCODE_WIDTH]).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
MDROut  input  DATA_WIDTH  RAM read data, valid the cycle after MAR is driven
MDRIn  output  DATA_WIDTH  RAM write data
RAMWr  output  1  RAM write enable
MAR  output  ADDRESS_WIDTH  RAM address
PC  output  ADDRESS_WIDTH  program counter
halted  output  1  high while in HALT state
carry  output  1  carry/borrow flag
zero  output  1  ACC == 0 flag
div_zero  output  1  sticky divide-by-zero flag
illegal  output  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst low, asynchronous): state=FETCH, PC=0, IR=0, ACC=0, carry=0, zero=1, div_zero=0, illegal=0, halted=0. MAR/MDRIn/RAMWr are combinational from state and are 0 while in reset.
- Default outputs each cycle: MAR=0, RAMWr=0, MDRIn=0.
- FETCH: MAR=PC -> DECODE.
- DECODE: IR<=MDROut; PC<=PC+1 (wraps modulo 2^ADDRESS_WIDTH) -> EXEC_A.
- EXEC_A, by opcode:
  - memory ops (0 LOD, 1 STO, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 10 AND, 11 OR, 12 XOR): MAR=operand -> EXEC_B.
  - 6 JMP: PC<=operand -> FETCH.
  - 7 JMZ: PC<=operand if ACC==0 -> FETCH.
  - 13 JMC: PC<=operand if carry -> FETCH.
  - 8 NOP -> FETCH.
  - 14 NOT: ACC<=~ACC -> FETCH.
  - 9 HLT -> HALT.
  - 15: illegal<=1 -> HALT.
- EXEC_B:
  - LOD: ACC<=MDROut.
  - STO: MAR=operand, MDRIn=ACC, RAMWr=1 for exactly this cycle.
  - ADD: {carry,ACC}<=ACC+MDROut (DATA_WIDTH+1-bit sum).
  - SUB: ACC<=ACC-MDROut; carry<=borrow (ACC<MDROut).
  - MUL: ACC<=low DATA_WIDTH bits of the product; carry<=(upper half != 0).
  - AND/OR/XOR: bitwise; carry unchanged.
  - Non-DIV ops then go to FETCH.
  - DIV with MDROut==0: ACC<=all ones, carry<=1, div_zero<=1 -> FETCH. No halt.
  - DIV otherwise: latch divisor, clear remainder, counter=DATA_WIDTH -> DIV.
- DIV: restoring unsigned division, one quotient bit per cycle, exactly DATA_WIDTH cycles. ACC<=quotient and carry<=(remainder != 0) on the last cycle -> FETCH.
- HALT: absorbing. No RAM access, PC frozen, halted=1. Only reset exits.
- zero always reflects the current ACC (ACC==0).
- Cycle counts: JMP/JMZ/JMC/NOP/NOT/HLT = 3; LOD/STO/ADD/SUB/MUL/logic = 4; DIV = 4+DATA_WIDTH; DIV by zero = 4.
- Reset mid-instruction, including mid-divide or during a STO write cycle: abandons immediately. RAMWr drops combinationally with reset assertion. Execution restarts at PC=0 after release.
- Unsigned arithmetic throughout. Operand field is zero-extended where compared or loaded into PC.

Optional Feature:
AVION_CPU_V2_DIV_EN.
- Defined: DIV opcode 5 and the DIV state are implemented as above.
- Undefined: the divider logic and DIV state are not synthesised. Opcode 5 is treated as illegal in EXEC_A (illegal<=1 -> HALT, no operand read). All other behaviour is identical.

Test Plan:
- Image LOD 50/ADD 51/STO 52/HLT with [50]=5, [51]=10 -> mem[52]=15, carry=0, halted=1. STO write pulse is 1 cycle. Halt is reached 15 cycles after reset release.
- Same image with MUL -> mem[52]=50, carry=0. With [50]=100, [51]=20 -> ACC=2000 mod 1024 = 976, carry=1.
- DIV (macro on): [50]=100, [51]=7 -> mem[52]=14, carry=1. The DIV instruction occupies 14 cycles. Divisor 0 -> ACC=1023, div_zero=1, execution continues to HLT.
- Loop program (sum 5 ten times via SUB/JMZ/JMP counter) -> mem[52]=50. Also checks ADD 0x3FF+1 -> ACC=0, carry=1, JMC taken, zero=1.
- Opcode 15 at address 0 -> illegal=1, halted=1, PC=1, RAMWr never asserted. Macro off with DIV at address 1 -> illegal=1, PC=2.
- Assert rst low during the DIV state and during the STO write cycle -> all state and flags return to reset values asynchronously, no spurious write. Program reruns from PC=0 to the correct result.

Source files
------------

// File: rtl/avion_cpu_v2.sv
// avion_cpu_v2: parametrised accumulator CPU driving a single-port RAM with one-cycle read latency.
// Define AVION_CPU_V2_DIV_EN to build the iterative divider (opcode 5); without it opcode 5 is illegal.
module avion_cpu_v2 #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int OPCODE_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    MDROut,
  output logic [DATA_WIDTH-1:0]    MDRIn,
  output logic                     RAMWr,
  output logic [ADDRESS_WIDTH-1:0] MAR,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic                     halted,
  output logic                     carry,
  output logic                     zero,
  output logic                     div_zero,
  output logic                     illegal
);
  if (DATA_WIDTH != OPCODE_WIDTH + ADDRESS_WIDTH) begin : g_width_check
    $error("avion_cpu_v2: DATA_WIDTH must equal OPCODE_WIDTH + ADDRESS_WIDTH");
  end

  typedef logic [OPCODE_WIDTH-1:0] op_t;
  localparam op_t OP_LOD = op_t'(0);
  localparam op_t OP_STO = op_t'(1);
  localparam op_t OP_ADD = op_t'(2);
  localparam op_t OP_SUB = op_t'(3);
  localparam op_t OP_MUL = op_t'(4);
  localparam op_t OP_DIV = op_t'(5);
  localparam op_t OP_JMP = op_t'(6);
  localparam op_t OP_JMZ = op_t'(7);
  localparam op_t OP_NOP = op_t'(8);
  localparam op_t OP_HLT = op_t'(9);
  localparam op_t OP_AND = op_t'(10);
  localparam op_t OP_OR  = op_t'(11);
  localparam op_t OP_XOR = op_t'(12);
  localparam op_t OP_JMC = op_t'(13);
  localparam op_t OP_NOT = op_t'(14);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC_A, S_EXEC_B, S_HALT
`ifdef AVION_CPU_V2_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t                   state;
  logic [DATA_WIDTH-1:0]    ir, acc;
  op_t                      opcode;
  logic [ADDRESS_WIDTH-1:0] operand;
  logic                     mem_op;
  logic [DATA_WIDTH:0]      sum, diff;
  logic [2*DATA_WIDTH-1:0]  prod;

  assign opcode  = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand = ir[ADDRESS_WIDTH-1:0];
  assign sum     = {1'b0, acc} + {1'b0, MDROut};
  assign diff    = {1'b0, acc} - {1'b0, MDROut};
  assign prod    = {{DATA_WIDTH{1'b0}}, acc} * {{DATA_WIDTH{1'b0}}, MDROut};
  assign halted  = (state == S_HALT);
  assign zero    = (acc == '0);

  always_comb begin
    mem_op = 1'b0;
    case (opcode)
      OP_LOD, OP_STO, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: mem_op = 1'b1;
`ifdef AVION_CPU_V2_DIV_EN
      OP_DIV: mem_op = 1'b1;
`endif
      default: mem_op = 1'b0;
    endcase
  end

`ifdef AVION_CPU_V2_DIV_EN
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  logic [DATA_WIDTH-1:0] dvsr, rem, rem_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH:0]   rem_sh, rem_sub;
  logic                  q_bit;

  // Dividend shifts out of ACC's MSB while quotient bits shift in at the LSB.
  assign rem_sh  = {rem, acc[DATA_WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, dvsr};
  assign q_bit   = ~rem_sub[DATA_WIDTH];
  assign rem_nxt = q_bit ? rem_sub[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
`endif

  // RAM strobes are gated by reset so a write in flight drops the moment reset asserts.
  always_comb begin
    MAR   = '0;
    MDRIn = '0;
    RAMWr = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH:  MAR = PC;
        S_EXEC_A: if (mem_op) MAR = operand;
        S_EXEC_B: if (opcode == OP_STO) begin
          MAR   = operand;
          MDRIn = acc;
          RAMWr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      PC       <= '0;
      ir       <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
`ifdef AVION_CPU_V2_DIV_EN
      dvsr     <= '0;
      rem      <= '0;
      cnt      <= '0;
`endif
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir    <= MDROut;
          PC    <= PC + ADDRESS_WIDTH'(1);
          state <= S_EXEC_A;
        end
        S_EXEC_A: begin
          state <= S_FETCH;
          case (opcode)
            OP_JMP: PC <= operand;
            OP_JMZ: if (acc == '0) PC <= operand;
            OP_JMC: if (carry) PC <= operand;
            OP_NOP: ;
            OP_NOT: acc <= ~acc;
            OP_HLT: state <= S_HALT;
            default: begin
              if (mem_op) state <= S_EXEC_B;
              else begin
                illegal <= 1'b1;
                state   <= S_HALT;
              end
            end
          endcase
        end
        S_EXEC_B: begin
          state <= S_FETCH;
          case (opcode)
            OP_LOD: acc <= MDROut;
            OP_ADD: {carry, acc} <= sum;
            OP_SUB: {carry, acc} <= diff;
            OP_MUL: begin
              acc   <= prod[DATA_WIDTH-1:0];
              carry <= |prod[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            OP_AND: acc <= acc & MDROut;
            OP_OR:  acc <= acc | MDROut;
            OP_XOR: acc <= acc ^ MDROut;
`ifdef AVION_CPU_V2_DIV_EN
            OP_DIV: begin
              if (MDROut == '0) begin
                acc      <= '1;
                carry    <= 1'b1;
                div_zero <= 1'b1;
              end else begin
                dvsr  <= MDROut;
                rem   <= '0;
                cnt   <= CNT_W'(DATA_WIDTH);
                state <= S_DIV;
              end
            end
`endif
            default: ;
          endcase
        end
`ifdef AVION_CPU_V2_DIV_EN
        S_DIV: begin
          acc <= {acc[DATA_WIDTH-2:0], q_bit};
          rem <= rem_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            carry <= (rem_nxt != '0);
            state <= S_FETCH;
          end
        end
`endif
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_avion_cpu_v2.sv
// Scoreboard bench for avion_cpu_v2: directed programs push expected RAM writes and halt status;
// a negedge monitor pops and compares them as the DUT presents writes or reaches HALT.
module tb_avion_cpu_v2;
  localparam int AW = 6;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] MDROut = '0;
  logic [DW-1:0] MDRIn;
  logic          RAMWr;
  logic [AW-1:0] MAR, PC;
  logic          halted, carry, zero, div_zero, illegal;

  avion_cpu_v2 #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OPCODE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .MDROut(MDROut), .MDRIn(MDRIn), .RAMWr(RAMWr), .MAR(MAR),
    .PC(PC), .halted(halted), .carry(carry), .zero(zero), .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] img [64];
  logic          load = 1'b0;

  always @(posedge clk) begin
    if (load) mem <= img;
    else if (RAMWr) mem[MAR] <= MDRIn;
    MDROut <= mem[MAR];
  end

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int cycles; int pc; int c; int z; int dz; int il; } hlt_t;
  typedef struct { string name; int act; int exp; } chk_t;

  wr_t  wq[$];
  hlt_t hq[$];
  chk_t sq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   wr_run = 0;
  bit   hseen = 1'b0;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic void cmp(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  initial begin : monitor
    wr_t  w;
    hlt_t h;
    chk_t c;
    forever begin
      @(negedge clk);
      while (sq.size() > 0) begin
        c = sq.pop_front();
        cmp(c.name, c.act, c.exp);
      end
      if (!rst) begin
        hseen  = 1'b0;
        wr_run = 0;
        if (RAMWr) cmp("wr_during_reset", 1, 0);
      end else begin
        if (RAMWr) begin
          wr_run++;
          if (wq.size() == 0) cmp("unexpected_wr_addr", int'(MAR), -1);
          else begin
            w = wq.pop_front();
            cmp("wr_addr", int'(MAR), w.addr);
            cmp("wr_data", int'(MDRIn), w.data);
          end
        end else if (wr_run != 0) begin
          cmp("wr_pulse_len", wr_run, 1);
          wr_run = 0;
        end
        if (halted && !hseen) begin
          hseen = 1'b1;
          if (hq.size() == 0) cmp("unexpected_halt", 1, 0);
          else begin
            h = hq.pop_front();
            if (h.cycles >= 0) cmp("halt_cycles", cyc, h.cycles);
            cmp("halt_pc", int'(PC), h.pc);
            cmp("halt_carry", int'(carry), h.c);
            cmp("halt_zero", int'(zero), h.z);
            cmp("halt_div_zero", int'(div_zero), h.dz);
            cmp("halt_illegal", int'(illegal), h.il);
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] ins(int op, int a);
    return DW'(op * 64 + a);
  endfunction

  task automatic chk(string name, int act, int exp);
    sq.push_back('{name: name, act: act, exp: exp});
  endtask

  task automatic exp_wr(int a, int d);
    wq.push_back('{addr: a, data: d});
  endtask

  task automatic exp_halt(int cy, int pc, int c, int z, int dz, int il);
    hq.push_back('{cycles: cy, pc: pc, c: c, z: z, dz: dz, il: il});
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = DW'(i * 7 + 3);
  endtask

  // Four-word program: LOD 50 / <op> 51 / STO 52 / HLT.
  task automatic img_arith(int op, int a, int b);
    clear_img();
    img[0] = ins(0, 50); img[1] = ins(op, 51); img[2] = ins(1, 52); img[3] = ins(9, 0);
    img[50] = DW'(a); img[51] = DW'(b);
  endtask

  // Reset is asserted synchronously to stimulus timing, not at a clock edge.
  task automatic rst_check();
    rst = 1'b0;
    #1;
    chk("rst_ramwr", int'(RAMWr), 0);
    chk("rst_mar", int'(MAR), 0);
    chk("rst_pc", int'(PC), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_div_zero", int'(div_zero), 0);
    chk("rst_illegal", int'(illegal), 0);
  endtask

  task automatic start();
    rst  = 1'b0;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic wait_halt(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (hseen) break;
    end
    if (!hseen) chk("halt_timeout", 0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("pending_writes", wq.size(), 0);
    chk("pending_halts", hq.size(), 0);
  endtask

  initial begin : stim
    bit got;
    #2;
    rst_check();

    img_arith(2, 5, 10);
    exp_wr(52, 15); exp_halt(15, 4, 0, 0, 0, 0);
    start(); wait_halt(100);

    img_arith(4, 5, 10);
    exp_wr(52, 50); exp_halt(15, 4, 0, 0, 0, 0);
    start(); wait_halt(100);

    img_arith(4, 100, 20);
    exp_wr(52, 976); exp_halt(15, 4, 1, 0, 0, 0);
    start(); wait_halt(100);

`ifdef AVION_CPU_V2_DIV_EN
    img_arith(5, 100, 7);
    exp_wr(52, 14); exp_halt(25, 4, 1, 0, 0, 0);
    start(); wait_halt(100);

    img_arith(5, 100, 0);
    exp_wr(52, 1023); exp_halt(15, 4, 1, 0, 1, 0);
    start(); wait_halt(100);
`else
    img_arith(5, 100, 7);
    exp_halt(7, 2, 0, 0, 0, 1);
    start(); wait_halt(100);
`endif

    clear_img();
    img[0] = ins(15, 0);
    exp_halt(3, 1, 0, 1, 0, 1);
    start(); wait_halt(100);

    // Counter loop adding 5 ten times, then 0x3FF+1 overflow and a taken JMC.
    clear_img();
    img[0]  = ins(0, 53); img[1]  = ins(7, 9);  img[2]  = ins(3, 54); img[3]  = ins(1, 53);
    img[4]  = ins(0, 52); img[5]  = ins(2, 55); img[6]  = ins(1, 52); img[7]  = ins(6, 0);
    img[9]  = ins(0, 56); img[10] = ins(2, 54); img[11] = ins(1, 57); img[12] = ins(13, 14);
    img[13] = ins(9, 0);  img[14] = ins(9, 0);
    img[52] = 10'd0; img[53] = 10'd10; img[54] = 10'd1; img[55] = 10'd5; img[56] = 10'h3FF;
    for (int i = 1; i <= 10; i++) begin
      exp_wr(53, 10 - i);
      exp_wr(52, 5 * i);
    end
    exp_wr(57, 0);
    exp_halt(325, 15, 1, 1, 0, 0);
    start(); wait_halt(500);

    // Reset landing on the STO write cycle: no write reaches RAM, then a clean rerun.
    img_arith(4, 100, 20);
    start();
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (RAMWr) begin
        got = 1'b1;
        break;
      end
    end
    chk("sto_reached", int'(got), 1);
    rst_check();
    repeat (2) @(posedge clk);
    #1;
    chk("no_spurious_wr", int'(mem[52]), int'(img[52]));
    exp_wr(52, 976); exp_halt(15, 4, 1, 0, 0, 0);
    start(); wait_halt(100);

    // Reset ten cycles into the program (inside the divide when the divider is built).
`ifdef AVION_CPU_V2_DIV_EN
    img_arith(5, 100, 7);
`else
    img_arith(4, 100, 20);
`endif
    start();
    repeat (10) @(posedge clk);
    #2;
    rst_check();
    repeat (2) @(posedge clk);
    #1;
    chk("no_write_mid_reset", int'(mem[52]), int'(img[52]));
`ifdef AVION_CPU_V2_DIV_EN
    exp_wr(52, 14); exp_halt(25, 4, 1, 0, 0, 0);
`else
    exp_wr(52, 976); exp_halt(15, 4, 1, 0, 0, 0);
`endif
    start(); wait_halt(100);

    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
